// File: rtl/vec_calc_sequencer.sv
// vec_calc_sequencer
//   Command-level controller for the lane-group vector add/multiply engine.
//   Accepts one full-width vector command, issues it to the engine as P =
//   LANES/G lane-group passes (one per cycle), collects the engine results
//   as they emerge ENG_LAT cycles later, and returns the assembled vector.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op                   00 add, 01 multiply, 1x illegal
//   cmd_a, cmd_b             LANES x W operands, lane i at [i*W +: W]
//   eng_sum, eng_multiply    engine strobes (one pass per cycle)
//   eng_a, eng_b             lane-group operands to the engine
//   eng_res                  engine lane-group result
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_err        assembled result, illegal-command flag
//   busy                     high whenever not idle
module vec_calc_sequencer #(
  parameter int LANES   = 32,
  parameter int W       = 16,
  parameter int G       = 8,
  parameter int ENG_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LANES*W-1:0] cmd_a,
  input  logic [LANES*W-1:0] cmd_b,
  output logic               eng_sum,
  output logic               eng_multiply,
  output logic [G*W-1:0]     eng_a,
  output logic [G*W-1:0]     eng_b,
  input  logic [G*W-1:0]     eng_res,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [LANES*W-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int P  = LANES / G;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]         state;
  logic [PW-1:0]      pass_cnt;
  logic [PW-1:0]      cap_cnt;
  logic [LANES*W-1:0] op_a;
  logic [LANES*W-1:0] op_b;
  logic [LANES*W-1:0] res;
  logic               op_mul;
  logic               err;
  logic [ENG_LAT-1:0] cap_pipe;
  logic               issuing;
  logic               capture;
  logic               last_pass;
  logic               last_cap;

  assign issuing   = (state == ISSUE);
  assign last_pass = (pass_cnt == PW'(P - 1));
  assign last_cap  = (cap_cnt == PW'(P - 1));
  // A pass issued in cycle c has its result on eng_res in cycle c+ENG_LAT;
  // the delay line marks that cycle so captures run alongside issue.
  assign capture   = cap_pipe[ENG_LAT-1];

  if (ENG_LAT > 1) begin : g_pipe_n
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cap_pipe <= '0;
      else        cap_pipe <= {cap_pipe[ENG_LAT-2:0], issuing};
    end
  end else begin : g_pipe_1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cap_pipe <= '0;
      else        cap_pipe <= issuing;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pass_cnt <= '0;
      cap_cnt  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      op_mul   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_a     <= cmd_a;
            op_b     <= cmd_b;
            op_mul   <= cmd_op[0];
            pass_cnt <= '0;
            cap_cnt  <= '0;
            res      <= '0;
            err      <= cmd_op[1];
            state    <= cmd_op[1] ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          pass_cnt <= last_pass ? '0 : pass_cnt + 1'b1;
          if (last_pass) state <= DRAIN;
        end
        DRAIN: begin
          if (capture && last_cap) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (capture) begin
        res[cap_cnt*G*W +: G*W] <= eng_res;
        cap_cnt <= last_cap ? '0 : cap_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    eng_a = '0;
    eng_b = '0;
    if (issuing) begin
      eng_a = op_a[pass_cnt*G*W +: G*W];
      eng_b = op_b[pass_cnt*G*W +: G*W];
    end
  end

  assign eng_sum      = issuing & ~op_mul;
  assign eng_multiply = issuing & op_mul;
  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign rsp_valid    = (state == RESP);
  assign rsp_data     = res;
  assign rsp_err      = err;

endmodule
